// File: rtl/dtc_rr_sched_if.sv
// Request/response handshake bundle between the front-end requesters, the
// dtc_rr_sched scheduler and the response consumer.
interface dtc_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int W       = 8,
    parameter int IDW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*W-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [W-1:0]         rsp_data;

    // The scheduler's view of the bundle.
    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

    // The view of the requesters and the response consumer.
    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/dtc_rr_sched.sv
// Round-robin scheduler sharing one combinational decision-tree classifier
// among NUM_REQ requesters through a two-stage (A: classifier input, B: response) pipeline.
module dtc_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int W       = 8,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    dtc_rr_sched_if.slave       bus,
    output logic [W-1:0]        o_dtc_inp,
    input  logic [W-1:0]        i_dtc_outp,
    output logic                o_busy,
    output logic [15:0]         o_acc_cnt
);

    logic               r_a_valid;
    logic [IDW-1:0]     r_a_id;
    logic [W-1:0]       r_dtc_inp;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [W-1:0]       r_rsp_data;
    logic [IDW-1:0]     r_ptr;
    logic [15:0]        r_acc_cnt;

    logic               w_b_free;
    logic               w_a_free;
    logic               w_grant_vld;
    logic [IDW-1:0]     w_grant_id;
    logic [IDW:0]       w_idx;
    logic               w_accept;
    logic               w_transfer;
    logic [W-1:0]       w_sel_data;
    logic [IDW-1:0]     w_ptr_next;
    logic [NUM_REQ-1:0] w_req_ready;

    assign w_b_free   = !r_rsp_valid || bus.rsp_ready;
    assign w_a_free   = !r_a_valid || w_b_free;
    assign w_transfer = r_a_valid && w_b_free;

    // Search upward from the priority pointer, wrapping modulo NUM_REQ; the first asserted request wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(i);
            if (w_idx >= (IDW+1)'(NUM_REQ)) begin
                w_idx = w_idx - (IDW+1)'(NUM_REQ);
            end
            if (!w_grant_vld && bus.req_valid[w_idx[IDW-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_idx[IDW-1:0];
            end
        end
    end

    assign w_accept   = w_grant_vld && i_en && w_a_free;
    assign w_sel_data = bus.req_data[int'(w_grant_id)*W +: W];
    assign w_ptr_next = (w_grant_id == IDW'(NUM_REQ-1)) ? '0 : w_grant_id + 1'b1;

    always_comb begin
        w_req_ready = '0;
        if (w_accept) begin
            w_req_ready[w_grant_id] = 1'b1;
        end
    end

    // Stage A: the registered classifier input; priority only rotates on an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_id    <= '0;
            r_dtc_inp <= '0;
            r_ptr     <= '0;
            r_acc_cnt <= '0;
        end else if (w_accept) begin
            r_a_valid <= 1'b1;
            r_a_id    <= w_grant_id;
            r_dtc_inp <= w_sel_data;
            r_ptr     <= w_ptr_next;
            r_acc_cnt <= r_acc_cnt + 16'd1;
        end else if (w_transfer) begin
            r_a_valid <= 1'b0;
        end
    end

    // Stage B: captures the classifier result and holds it until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else if (w_transfer) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_a_id;
            r_rsp_data  <= i_dtc_outp;
        end else if (r_rsp_valid && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign o_dtc_inp     = r_dtc_inp;
    assign o_busy        = r_a_valid || r_rsp_valid;
    assign o_acc_cnt     = r_acc_cnt;

endmodule

// File: tb/tb_dtc_rr_sched.sv
// Directed bench for dtc_rr_sched with a small decision-tree classifier wired
// onto the dtc_inp/dtc_outp ports.
module tb_dtc_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  dtcInp;
    logic [7:0]  dtcOutp;
    logic        busy;
    logic [15:0] accCnt;
    int          testCount = 0;
    int          failCount = 0;

    logic [7:0] rrData  [4] = '{8'h05, 8'h47, 8'h9A, 8'hC3};
    logic [7:0] rrClass [4] = '{8'h11, 8'h33, 8'hA1, 8'hA2};

    dtc_rr_sched_if #(.NUM_REQ(4), .W(8)) bus ();

    dtc_rr_sched #(.NUM_REQ(4), .W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (en),
        .bus        (bus),
        .o_dtc_inp  (dtcInp),
        .i_dtc_outp (dtcOutp),
        .o_busy     (busy),
        .o_acc_cnt  (accCnt)
    );

    always #5 clk = ~clk;

    // Stand-in classifier: a three-level decision tree on the feature byte.
    function automatic logic [7:0] dtcClassify(input logic [7:0] x);
        if (x[7]) return (x[3:0] > 4'd5) ? 8'hA1 : 8'hA2;
        else if (x < 8'h30) return x[0] ? 8'h11 : 8'h12;
        else return x[1] ? 8'h33 : 8'h34;
    endfunction

    assign dtcOutp = dtcClassify(dtcInp);

    task automatic applyStimulus(input logic [3:0] valid, input logic enable, input logic rspReady);
        bus.req_valid = valid;
        en            = enable;
        bus.rsp_ready = rspReady;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        en            = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst           = 1'b1;
        en            = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = {rrData[3], rrData[2], rrData[1], rrData[0]};
        bus.rsp_ready = 1'b1;
        #3;
        checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset acc_cnt", 32'(accCnt), 32'h0);
        checkOutput("reset dtc_inp", 32'(dtcInp), 32'h0);
        checkOutput("reset rsp_id", 32'(bus.rsp_id), 32'h0);
        checkOutput("reset rsp_data", 32'(bus.rsp_data), 32'h0);
        checkOutput("reset req_ready", 32'(bus.req_ready), 32'h0);
        tick();
        rst = 1'b0;

        // Single request from requester 0 with feature 0x2C.
        bus.req_data[7:0] = 8'h2C;
        applyStimulus(4'b0001, 1'b1, 1'b1);
        checkOutput("single req_ready", 32'(bus.req_ready), 32'h1);
        tick();
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("single dtc_inp", 32'(dtcInp), 32'h2C);
        checkOutput("single rsp_valid early", 32'(bus.rsp_valid), 32'h0);
        tick();
        checkOutput("single rsp_valid", 32'(bus.rsp_valid), 32'h1);
        checkOutput("single rsp_id", 32'(bus.rsp_id), 32'h0);
        checkOutput("single rsp_data", 32'(bus.rsp_data), 32'h12);
        checkOutput("single acc_cnt", 32'(accCnt), 32'h1);
        tick();
        checkOutput("single drained busy", 32'(busy), 32'h0);

        // Round robin with all four requesters held high.
        resetDut();
        bus.req_data = {rrData[3], rrData[2], rrData[1], rrData[0]};
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 1'b1, 1'b1);
            checkOutput("rr req_ready", 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            checkOutput("rr dtc_inp", 32'(dtcInp), 32'(rrData[k % 4]));
            if (k > 0) begin
                checkOutput("rr rsp_valid", 32'(bus.rsp_valid), 32'h1);
                checkOutput("rr rsp_id", 32'(bus.rsp_id), 32'((k - 1) % 4));
                checkOutput("rr rsp_data", 32'(bus.rsp_data), 32'(rrClass[(k - 1) % 4]));
            end
        end
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("rr acc_cnt", 32'(accCnt), 32'd8);
        tick();
        checkOutput("rr last rsp_id", 32'(bus.rsp_id), 32'h3);
        checkOutput("rr last rsp_data", 32'(bus.rsp_data), 32'hA2);
        tick();
        checkOutput("rr drained rsp_valid", 32'(bus.rsp_valid), 32'h0);

        // Backpressure: requesters 1 and 3 active, consumer stalled for five edges.
        resetDut();
        applyStimulus(4'b1010, 1'b1, 1'b0);
        checkOutput("bp first req_ready", 32'(bus.req_ready), 32'b0010);
        tick();
        checkOutput("bp second req_ready", 32'(bus.req_ready), 32'b1000);
        tick();
        for (int s = 0; s < 3; s++) begin
            checkOutput("bp stall req_ready", 32'(bus.req_ready), 32'h0);
            checkOutput("bp stall rsp_id", 32'(bus.rsp_id), 32'h1);
            checkOutput("bp stall rsp_data", 32'(bus.rsp_data), 32'h33);
            checkOutput("bp stall dtc_inp", 32'(dtcInp), 32'hC3);
            tick();
        end
        checkOutput("bp stall acc_cnt", 32'(accCnt), 32'd2);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("bp pop1 rsp_valid", 32'(bus.rsp_valid), 32'h1);
        checkOutput("bp pop1 rsp_id", 32'(bus.rsp_id), 32'h1);
        tick();
        checkOutput("bp pop2 rsp_valid", 32'(bus.rsp_valid), 32'h1);
        checkOutput("bp pop2 rsp_id", 32'(bus.rsp_id), 32'h3);
        checkOutput("bp pop2 rsp_data", 32'(bus.rsp_data), 32'hA2);
        tick();
        checkOutput("bp empty rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("bp acc_cnt", 32'(accCnt), 32'd2);

        // Priority persistence across idle cycles.
        resetDut();
        applyStimulus(4'b0100, 1'b1, 1'b1);
        checkOutput("prio req2 req_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        applyStimulus(4'b0000, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        applyStimulus(4'b0101, 1'b1, 1'b1);
        checkOutput("prio wrap req_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        checkOutput("prio wrap dtc_inp", 32'(dtcInp), 32'h05);

        // Enable low: no acceptance while the in-flight A entry still emerges.
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("en0 req_ready", 32'(bus.req_ready), 32'h0);
        tick();
        checkOutput("en0 rsp_valid", 32'(bus.rsp_valid), 32'h1);
        checkOutput("en0 rsp_id", 32'(bus.rsp_id), 32'h0);
        checkOutput("en0 rsp_data", 32'(bus.rsp_data), 32'h11);
        checkOutput("en0 acc_cnt", 32'(accCnt), 32'd2);
        checkOutput("en0 busy", 32'(busy), 32'h1);

        // Asynchronous reset while busy, checked before the next clock edge.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("async rst busy", 32'(busy), 32'h0);
        checkOutput("async rst acc_cnt", 32'(accCnt), 32'h0);
        checkOutput("async rst dtc_inp", 32'(dtcInp), 32'h0);
        #1;
        rst = 1'b0;

        // Accepted-request counter wraps from 0xFFFF to 0.
        applyStimulus(4'b0000, 1'b1, 1'b1);
        tick();
        force dut.r_acc_cnt = 16'hFFFF;
        #1;
        release dut.r_acc_cnt;
        #1;
        checkOutput("wrap preload", 32'(accCnt), 32'hFFFF);
        applyStimulus(4'b0001, 1'b1, 1'b1);
        tick();
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("wrap acc_cnt", 32'(accCnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/dtc_rr_sched.md
# dtc_rr_sched

Round-robin scheduler that shares one combinational decision-tree classifier (8-bit feature vector in, 8-bit class code out) among NUM_REQ requesters. It arbitrates valid/ready requests, registers the granted feature vector onto the classifier input, and captures the classifier output into a tagged response register with backpressure. It sits between the feature-producing front ends and the single classifier instance, which is instantiated beside it and wired through the dtc_inp/dtc_outp ports.

## Interface
- NUM_REQ, 4: number of requesters, 2..16
- W, 8: feature and class-code width, equal to the classifier width
- IDW, $clog2(NUM_REQ): requester-id width
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  grant enable; 0 blocks new acceptances, in-flight data still drains
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  NUM_REQ*W  feature vectors; requester i uses bits [i*W +: W]
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- dtc_inp  out  W  registered feature vector driven to the classifier
- dtc_outp  in  W  classifier result, combinational function of dtc_inp
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  requester index of the response
- rsp_data  out  W  class code
- busy  out  1  a_valid | rsp_valid
- acc_cnt  out  16  accepted-request count, wraps at 0xFFFF -> 0

## Operation
- Two register stages:
  - A holds a_valid, a_id and dtc_inp.
  - B holds rsp_valid, rsp_id and rsp_data.
- b_free = !rsp_valid | rsp_ready.
- a_free = !a_valid | b_free.
- Arbitration is combinational. Among asserted req_valid bits, the grant goes to the first index found searching upward from ptr, wrapping modulo NUM_REQ.
- req_ready[g] = en & a_free & grant[g]. All other req_ready bits are 0.
- Accept, when req_valid[g] & req_ready[g]:
  - dtc_inp <= req_data[g]; a_id <= g; a_valid <= 1.
  - ptr <= (g+1) mod NUM_REQ.
  - acc_cnt increments.
- ptr changes only on an accept. An idle cycle or a stall does not rotate priority.
- Transfer A->B when a_valid & b_free: rsp_data <= dtc_outp, rsp_id <= a_id, rsp_valid <= 1.
- If no accept happens in the same cycle as a transfer, a_valid <= 0.
- Response handshake: when rsp_valid & rsp_ready and no transfer in the same cycle, rsp_valid <= 0.
- Simultaneous events:
  - Accept, A->B transfer and response pop may all occur in one cycle. The pipeline then sustains 1 result/cycle.
  - If rsp_ready is held low with B full, A holds its value and req_ready stays 0. No data is lost or duplicated.
  - When en falls, the current cycle's acceptance is still governed combinationally by en. Stages A and B drain normally.
- Outputs stay stable while rsp_valid=1 and rsp_ready=0.
- Fairness: a continuously asserting requester is granted within NUM_REQ accepts.

## Timing
- Reset (async assert, sync deassert by the integrator):
  - a_valid=0, rsp_valid=0, dtc_inp=0, rsp_id=0, rsp_data=0.
  - ptr=0, acc_cnt=0, busy=0, req_ready=0.
- Latency: accept at edge N -> dtc_inp valid after edge N -> rsp_valid=1 after edge N+1, given B is free.
- req_ready depends combinationally on req_valid, en, ptr, rsp_ready. It does not depend on any consumer path through the classifier.
- Classifier path: dtc_inp register -> dtc_outp -> rsp_data register. This is one full cycle.
- Reset mid-operation: in-flight A/B contents are discarded and ptr returns to 0 immediately on rst assertion.

## Test plan
- Single request: NUM_REQ=4, rsp_ready=1, req_valid=0001, req_data[0]=0x2C.
  - req_ready=0001 in that cycle.
  - One cycle later, dtc_inp=0x2C.
  - Next cycle: rsp_valid=1, rsp_id=0, rsp_data = golden classifier(0x2C). acc_cnt=1.
- Round-robin: all four req_valid held high with rsp_ready=1 for 8 accepts.
  - Grant order is 0,1,2,3,0,1,2,3.
  - One response per cycle after the 2-cycle fill.
  - acc_cnt=8.
- Backpressure: hold rsp_ready=0 for 5 cycles with requesters 1 and 3 active.
  - After two accepts, req_ready=0000 and B holds id 1 stable.
  - On release, id 1 then id 3 are delivered with no loss and no duplicate.
- Priority persistence: accept requester 2, idle 3 cycles, then assert req_valid=0101.
  - Requester 0 is granted, because ptr=3 wraps to 0.
- Enable and reset:
  - en=0 with req_valid=1111 gives req_ready=0000, while the in-flight A entry still emerges.
  - Asserting rst while busy=1 clears rsp_valid and busy asynchronously. acc_cnt=0.
- Counter wrap: preload by 65535 accepts (or a force). The next accept gives acc_cnt=0x0000.
